// File: rtl/gl_pkg.sv
// Shared opcode map, instruction field layout and GL state constants
// for the GL command front end.
package gl_pkg;

  localparam int INST_W   = 32;
  localparam int OPC_W    = 8;
  localparam int IMM_W    = 23;
  localparam int OPC_LSB  = 0;
  localparam int IMM_LSB  = 8;
  localparam int TYPE_BIT = 31;
  localparam int BEAT_W   = 2;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_NOP             = 8'h00;
  localparam opcode_t OP_VIEWPORT        = 8'h01;
  localparam opcode_t OP_PUSH            = 8'h02;
  localparam opcode_t OP_POP             = 8'h03;
  localparam opcode_t OP_COLOR           = 8'h04;
  localparam opcode_t OP_MATRIX_MODE     = 8'h05;
  localparam opcode_t OP_LOAD_IDENTITY   = 8'h06;
  localparam opcode_t OP_LOAD_MATRIX     = 8'h07;
  localparam opcode_t OP_MULT_MATRIX     = 8'h08;
  localparam opcode_t OP_PERSPECTIVE_DIV = 8'h09;

  localparam logic MODE_MODELVIEW  = 1'b0;
  localparam logic MODE_PROJECTION = 1'b1;

  localparam logic [31:0] COLOR_RESET = 32'hFFFF_FFFF;

  localparam logic [BEAT_W-1:0] LAST_BEAT = 2'd3;

  // Bit order mirrors the word: [31] type, [30:8] imm, [7:0] opcode.
  typedef struct packed {
    logic             op_type;
    logic [IMM_W-1:0] imm;
    opcode_t          opcode;
  } gl_inst_t;

  function automatic logic is_multi(
    input opcode_t op
  );
    return (op == OP_LOAD_MATRIX) ||
           (op == OP_MULT_MATRIX);
  endfunction

endpackage

// File: rtl/gl_fetch_stage.sv
// Fetch stage: PC, instruction register and its address,
// all frozen while decode reports stall.
module gl_fetch_stage
  import gl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [DATA_W-1:0] inst_in,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_addr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      ir_addr <= '0;
    end else if (!stall) begin
      ir      <= inst_in;
      ir_addr <= pc;
      pc      <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/gl_fetch_decode.sv
// GL command front end: fetch plus decode into strobes and GL state.
// Optional GL_ILLEGAL_OPCODE_DETECT_EN adds illegal_op/illegal_seen.
module gl_fetch_decode
  import gl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_in,
  output logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_rd_0,
  input  logic [DATA_W-1:0] data_rd_1,
  input  logic [DATA_W-1:0] data_rd_2,
  input  logic [DATA_W-1:0] data_rd_3,
  output logic [31:0]       viewport_x,
  output logic [31:0]       viewport_y,
  output logic [31:0]       viewport_width,
  output logic [31:0]       viewport_height,
  output logic [31:0]       color_out,
  output logic              matrix_mode_out,
  output logic              push_en,
  output logic              pop_en,
  output logic              matrix_load_id_en,
  output logic              matrix_load_en,
  output logic              matrix_mul_en,
  output logic              matrix_mul_type,
  output logic [1:0]        matrix_row,
  output logic [31:0]       matrix_data_0,
  output logic [31:0]       matrix_data_1,
  output logic [31:0]       matrix_data_2,
  output logic [31:0]       matrix_data_3,
  output logic              perspective_div_en,
  output logic              stall
`ifdef GL_ILLEGAL_OPCODE_DETECT_EN
  ,
  output logic              illegal_op,
  output logic              illegal_seen
`endif
);

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] ir_addr;
  logic [BEAT_W-1:0] beat;
  logic [ADDR_W-1:0] base;
  gl_inst_t          inst;
  logic              multi;
  logic              vp_we;
  logic              col_imm_we;
  logic              col_mem_we;
  logic              mode_we;

  gl_fetch_stage #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC (RESET_PC)
  ) u_fetch (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .inst_in (inst_in),
    .pc      (pc),
    .ir      (ir),
    .ir_addr (ir_addr)
  );

  assign inst_addr = pc;
  assign inst      = gl_inst_t'(ir[INST_W-1:0]);
  assign multi     = is_multi(inst.opcode);

  // Operands are PC-relative to the decoded word; beats step by 4 words.
  assign base      = ir_addr + ADDR_W'(inst.imm);
  assign data_addr = base + ADDR_W'({beat, 2'b00});

  assign stall      = multi && (beat != LAST_BEAT);
  assign matrix_row = multi ? beat : '0;

  assign matrix_data_0 = 32'(data_rd_0);
  assign matrix_data_1 = 32'(data_rd_1);
  assign matrix_data_2 = 32'(data_rd_2);
  assign matrix_data_3 = 32'(data_rd_3);

  always_comb begin
    push_en            = 1'b0;
    pop_en             = 1'b0;
    matrix_load_id_en  = 1'b0;
    matrix_load_en     = 1'b0;
    matrix_mul_en      = 1'b0;
    matrix_mul_type    = 1'b0;
    perspective_div_en = 1'b0;
    vp_we              = 1'b0;
    col_imm_we         = 1'b0;
    col_mem_we         = 1'b0;
    mode_we            = 1'b0;
    unique case (1'b1)
      inst.opcode == OP_VIEWPORT:
        vp_we = inst.op_type;
      inst.opcode == OP_PUSH:
        push_en = 1'b1;
      inst.opcode == OP_POP:
        pop_en = 1'b1;
      inst.opcode == OP_COLOR: begin
        col_imm_we = !inst.op_type;
        col_mem_we = inst.op_type;
      end
      inst.opcode == OP_MATRIX_MODE:
        mode_we = 1'b1;
      inst.opcode == OP_LOAD_IDENTITY:
        matrix_load_id_en = 1'b1;
      inst.opcode == OP_LOAD_MATRIX:
        matrix_load_en = 1'b1;
      inst.opcode == OP_MULT_MATRIX: begin
        matrix_mul_en   = 1'b1;
        matrix_mul_type = inst.imm[0];
      end
      inst.opcode == OP_PERSPECTIVE_DIV:
        perspective_div_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat <= '0;
    end else if (multi) begin
      beat <= beat + BEAT_W'(1);
    end else begin
      beat <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      viewport_x      <= '0;
      viewport_y      <= '0;
      viewport_width  <= '0;
      viewport_height <= '0;
    end else if (vp_we) begin
      viewport_x      <= 32'(data_rd_0);
      viewport_y      <= 32'(data_rd_1);
      viewport_width  <= 32'(data_rd_2);
      viewport_height <= 32'(data_rd_3);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      color_out <= COLOR_RESET;
    end else if (col_imm_we) begin
      color_out <= {9'b0, inst.imm};
    end else if (col_mem_we) begin
      color_out <= 32'(data_rd_0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      matrix_mode_out <= MODE_MODELVIEW;
    end else if (mode_we) begin
      matrix_mode_out <= inst.imm[0];
    end
  end

`ifdef GL_ILLEGAL_OPCODE_DETECT_EN
  assign illegal_op = inst.opcode > OP_PERSPECTIVE_DIV;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_seen <= 1'b0;
    end else if (illegal_op) begin
      illegal_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gl_fetch_decode.sv
// Directed bench for gl_fetch_decode with small instruction and
// operand memories; expected values are hand-computed constants.
module tb_gl_fetch_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] inst_addr, inst_in, data_addr;
  logic [31:0] data_rd_0, data_rd_1, data_rd_2, data_rd_3;
  logic [31:0] viewport_x, viewport_y, viewport_width, viewport_height;
  logic [31:0] color_out;
  logic        matrix_mode_out;
  logic        push_en, pop_en, matrix_load_id_en;
  logic        matrix_load_en, matrix_mul_en, matrix_mul_type;
  logic [1:0]  matrix_row;
  logic [31:0] matrix_data_0, matrix_data_1, matrix_data_2, matrix_data_3;
  logic        perspective_div_en, stall;
`ifdef GL_ILLEGAL_OPCODE_DETECT_EN
  logic        illegal_op, illegal_seen;
`endif

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic [5:0]  strb;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign inst_in   = imem[inst_addr[7:0]];
  assign data_rd_0 = dmem[data_addr[7:0]];
  assign data_rd_1 = dmem[data_addr[7:0] + 8'd1];
  assign data_rd_2 = dmem[data_addr[7:0] + 8'd2];
  assign data_rd_3 = dmem[data_addr[7:0] + 8'd3];

  // push, pop, load_id, load, mul, persp
  assign strb = {push_en, pop_en, matrix_load_id_en,
                 matrix_load_en, matrix_mul_en, perspective_div_en};

  gl_fetch_decode dut (
    .clk                (clk),
    .reset              (reset),
    .inst_addr          (inst_addr),
    .inst_in            (inst_in),
    .data_addr          (data_addr),
    .data_rd_0          (data_rd_0),
    .data_rd_1          (data_rd_1),
    .data_rd_2          (data_rd_2),
    .data_rd_3          (data_rd_3),
    .viewport_x         (viewport_x),
    .viewport_y         (viewport_y),
    .viewport_width     (viewport_width),
    .viewport_height    (viewport_height),
    .color_out          (color_out),
    .matrix_mode_out    (matrix_mode_out),
    .push_en            (push_en),
    .pop_en             (pop_en),
    .matrix_load_id_en  (matrix_load_id_en),
    .matrix_load_en     (matrix_load_en),
    .matrix_mul_en      (matrix_mul_en),
    .matrix_mul_type    (matrix_mul_type),
    .matrix_row         (matrix_row),
    .matrix_data_0      (matrix_data_0),
    .matrix_data_1      (matrix_data_1),
    .matrix_data_2      (matrix_data_2),
    .matrix_data_3      (matrix_data_3),
    .perspective_div_en (perspective_div_en),
    .stall              (stall)
`ifdef GL_ILLEGAL_OPCODE_DETECT_EN
    ,
    .illegal_op         (illegal_op),
    .illegal_seen       (illegal_seen)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 32'h1000 + i;
    end
    dmem[8]  = 32'd10;
    dmem[9]  = 32'd20;
    dmem[10] = 32'd640;
    dmem[11] = 32'd480;
    dmem[43] = 32'hAABB_CCDD;

    // Reset state and NOP stream
    #12;
    chk("rst_pc", inst_addr, 32'd0);
    chk("rst_color", color_out, 32'hFFFF_FFFF);
    chk("rst_strb", 32'(strb), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_vp_w", viewport_width, 32'd0);
    chk("rst_mode", 32'(matrix_mode_out), 32'd0);
    @(negedge clk) reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("nop_pc", inst_addr, 32'(i));
      chk("nop_strb", 32'(strb), 32'd0);
    end
    chk("nop_color", color_out, 32'hFFFF_FFFF);

    // Main program
    reset = 1'b0;
    #1;
    imem[0] = 32'h8000_0801;
    imem[1] = 32'h1234_5604;
    imem[2] = 32'h0000_1007;
    imem[3] = 32'h8000_2804;
    imem[4] = 32'h0000_0002;
    imem[5] = 32'h0000_0003;
    imem[6] = 32'h0000_0006;
    imem[7] = 32'h0000_0009;
    imem[8] = 32'h0000_0105;
    imem[9] = 32'h0000_0108;
    @(negedge clk) reset = 1'b1;

    step();
    chk("vp_daddr", data_addr, 32'd8);
    chk("vp_pc", inst_addr, 32'd1);
    chk("vp_before", viewport_x, 32'd0);
    step();
    chk("vp_x", viewport_x, 32'd10);
    chk("vp_y", viewport_y, 32'd20);
    chk("vp_w", viewport_width, 32'd640);
    chk("vp_h", viewport_height, 32'd480);
    chk("col_before", color_out, 32'hFFFF_FFFF);
    step();
    chk("col_imm", color_out, 32'h0012_3456);
    chk("ld0_daddr", data_addr, 32'd18);
    chk("ld0_row", 32'(matrix_row), 32'd0);
    chk("ld0_stall", 32'(stall), 32'd1);
    chk("ld0_strb", 32'(strb), 32'b000100);
    chk("ld0_data0", matrix_data_0, 32'h1012);
    chk("ld0_data3", matrix_data_3, 32'h1015);
    chk("ld0_pc", inst_addr, 32'd3);
    step();
    chk("ld1_daddr", data_addr, 32'd22);
    chk("ld1_row", 32'(matrix_row), 32'd1);
    chk("ld1_stall", 32'(stall), 32'd1);
    chk("ld1_pc", inst_addr, 32'd3);
    step();
    chk("ld2_daddr", data_addr, 32'd26);
    chk("ld2_row", 32'(matrix_row), 32'd2);
    chk("ld2_stall", 32'(stall), 32'd1);
    step();
    chk("ld3_daddr", data_addr, 32'd30);
    chk("ld3_row", 32'(matrix_row), 32'd3);
    chk("ld3_stall", 32'(stall), 32'd0);
    chk("ld3_strb", 32'(strb), 32'b000100);
    chk("ld3_pc", inst_addr, 32'd3);
    step();
    chk("cm_pc", inst_addr, 32'd4);
    chk("cm_daddr", data_addr, 32'd43);
    chk("cm_row", 32'(matrix_row), 32'd0);
    chk("cm_strb", 32'(strb), 32'd0);
    step();
    chk("col_mem", color_out, 32'hAABB_CCDD);
    chk("push", 32'(strb), 32'b100000);
    step();
    chk("pop", 32'(strb), 32'b010000);
    step();
    chk("load_id", 32'(strb), 32'b001000);
    step();
    chk("persp", 32'(strb), 32'b000001);
    step();
    chk("mm_strb", 32'(strb), 32'd0);
    chk("mm_before", 32'(matrix_mode_out), 32'd0);
    step();
    chk("mm_after", 32'(matrix_mode_out), 32'd1);
    chk("mul0_strb", 32'(strb), 32'b000010);
    chk("mul0_type", 32'(matrix_mul_type), 32'd1);
    chk("mul0_daddr", data_addr, 32'd10);
    chk("mul0_stall", 32'(stall), 32'd1);
    step();
    chk("mul1_row", 32'(matrix_row), 32'd1);
    chk("mul1_daddr", data_addr, 32'd14);
    chk("mul1_pc", inst_addr, 32'd10);

    // Asynchronous reset in the middle of beat 1
    #2;
    reset = 1'b0;
    #1;
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_mul", 32'(matrix_mul_en), 32'd0);
    chk("arst_pc", inst_addr, 32'd0);
    chk("arst_row", 32'(matrix_row), 32'd0);
    chk("arst_color", color_out, 32'hFFFF_FFFF);
    chk("arst_vp", viewport_x, 32'd0);

    imem[0] = 32'h0000_0105;
    imem[1] = 32'h0000_000A;
    imem[2] = 32'h0000_0000;
    @(negedge clk) reset = 1'b1;
    step();
    chk("mm2_before", 32'(matrix_mode_out), 32'd0);
    step();
    chk("mm2_after", 32'(matrix_mode_out), 32'd1);
    chk("undef_strb", 32'(strb), 32'd0);
    chk("undef_stall", 32'(stall), 32'd0);
`ifdef GL_ILLEGAL_OPCODE_DETECT_EN
    chk("ill_op", 32'(illegal_op), 32'd1);
`endif
    step();
    chk("undef_pc", inst_addr, 32'd3);
    chk("undef_mode", 32'(matrix_mode_out), 32'd1);
`ifdef GL_ILLEGAL_OPCODE_DETECT_EN
    chk("ill_op_clr", 32'(illegal_op), 32'd0);
    chk("ill_seen", 32'(illegal_seen), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
